// File: rtl/count_wrap_tracker_pkg.sv
// count_wrap_tracker_pkg
//   Shared definitions for the counter wrap tracker: FSM state encoding,
//   step classification codes and default counter/extension widths.
package count_wrap_tracker_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned EXT_W_DEF = 8;

  typedef enum logic [1:0] {
    SYNC,
    TRACK,
    RESYNC
  } state_t;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_WRAP_UP,
    STEP_WRAP_DOWN,
    STEP_JUMP
  } step_t;

endpackage

// File: rtl/count_step_classifier.sv
// count_step_classifier
//   Purely combinational classification of the step between the last
//   captured counter value and the current one.
//   Ports:
//     prev  - previously captured counter value
//     count - current counter value
//     step  - HOLD / UP / DOWN / WRAP_UP / WRAP_DOWN / JUMP
module count_step_classifier
  import count_wrap_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] count,
  output step_t            step
);

  logic [CNT_W-1:0] delta;

  always_comb begin
    delta = count - prev;
    step  = STEP_JUMP;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == CNT_W'(1)) begin
      step = (prev == '1) ? STEP_WRAP_UP : STEP_UP;
    end else if (delta == '1) begin
      step = (prev == '0) ? STEP_WRAP_DOWN : STEP_DOWN;
    end
  end

endmodule

// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker
//   Monitors an upstream up/down counter and extends it with a high field
//   that follows wraps, flagging discontinuities and direction errors.
//   Optional feature: define COUNT_MATCH_IRQ_EN to enable the compare-match
//   interrupt; without it match_irq is tied low and cmp_val/irq_ack unused.
//   Ports:
//     clk, rst_n   - clock, asynchronous active-low reset
//     count        - registered counter value from upstream
//     mode         - counter direction (1 = up), same cycle as counter
//     ld, clr      - counter load/clear, same cycle as counter
//     cmp_val      - match compare value for ext_count
//     irq_ack      - acknowledge of match_irq
//     ext_count    - {high, prev}
//     ovf_pulse    - one-cycle wrap-up indication
//     unf_pulse    - one-cycle wrap-down indication
//     step_err     - sticky discontinuity / direction error
//     ext_ovf      - sticky high-field wrap
//     match_irq    - level compare-match interrupt
module count_wrap_tracker
  import count_wrap_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned EXT_W = EXT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       count,
  input  logic                   mode,
  input  logic                   ld,
  input  logic                   clr,
  input  logic [EXT_W+CNT_W-1:0] cmp_val,
  input  logic                   irq_ack,
  output logic [EXT_W+CNT_W-1:0] ext_count,
  output logic                   ovf_pulse,
  output logic                   unf_pulse,
  output logic                   step_err,
  output logic                   ext_ovf,
  output logic                   match_irq
);

  state_t           state_q, state_d;
  step_t            step;
  logic [CNT_W-1:0] prev_q;
  logic [EXT_W-1:0] high_q;
  logic             mode_q;
  logic             ovf_q, unf_q, err_q, xovf_q;
  logic             step_up, step_dn;

  count_step_classifier #(.CNT_W(CNT_W)) u_classifier (
    .prev  (prev_q),
    .count (count),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    state_d = TRACK;
      TRACK:   if (ld || clr) state_d = RESYNC;
      RESYNC:  if (!(ld || clr)) state_d = TRACK;
      default: state_d = SYNC;
    endcase
  end

  assign step_up = (step == STEP_UP)   || (step == STEP_WRAP_UP);
  assign step_dn = (step == STEP_DOWN) || (step == STEP_WRAP_DOWN);

  // mode_q is the direction the counter obeyed when producing the current
  // count, so it is what the observed step must agree with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      high_q <= '0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      err_q  <= 1'b0;
      xovf_q <= 1'b0;
    end else begin
      prev_q <= count;
      mode_q <= mode;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      if (state_q == TRACK) begin
        if ((step_up && !mode_q) || (step_dn && mode_q) || (step == STEP_JUMP))
          err_q <= 1'b1;
        if (step == STEP_WRAP_UP) begin
          high_q <= high_q + EXT_W'(1);
          ovf_q  <= 1'b1;
          if (high_q == '1) xovf_q <= 1'b1;
        end
        if (step == STEP_WRAP_DOWN) begin
          high_q <= high_q - EXT_W'(1);
          unf_q  <= 1'b1;
          if (high_q == '0) xovf_q <= 1'b1;
        end
      end else begin
        high_q <= '0;
      end
    end
  end

  assign ext_count = {high_q, prev_q};
  assign ovf_pulse = ovf_q;
  assign unf_pulse = unf_q;
  assign step_err  = err_q;
  assign ext_ovf   = xovf_q;

`ifdef COUNT_MATCH_IRQ_EN
  logic irq_q;

  // A new match wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    irq_q <= 1'b0;
    else if (ext_count == cmp_val) irq_q <= 1'b1;
    else if (irq_ack)              irq_q <= 1'b0;
  end

  assign match_irq = irq_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cmp_val, irq_ack};
  assign match_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_count_wrap_tracker.sv
// tb_count_wrap_tracker
//   Drives an upstream up/down counter into count_wrap_tracker and checks
//   against a reference that treats ext_count as one wide counter stepping
//   by +/-1. Honours COUNT_MATCH_IRQ_EN the same way as the design.
module tb_count_wrap_tracker;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXT_W = 8;
  localparam int unsigned W     = EXT_W + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n   = 1'b0;
  logic             mode    = 1'b1;
  logic             ld      = 1'b0;
  logic             clr     = 1'b0;
  logic             en      = 1'b0;
  logic             ovr     = 1'b0;
  logic             irq_ack = 1'b0;
  logic [CNT_W-1:0] ld_val  = '0;
  logic [CNT_W-1:0] ovr_val = '0;
  logic [CNT_W-1:0] cnt     = '0;
  logic [W-1:0]     cmp_val = '0;
  logic [W-1:0]     ext_count;
  logic             ovf_pulse, unf_pulse, step_err, ext_ovf, match_irq;

  int n_tests = 0;
  int n_fail  = 0;

  count_wrap_tracker #(.CNT_W(CNT_W), .EXT_W(EXT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count     (cnt),
    .mode      (mode),
    .ld        (ld),
    .clr       (clr),
    .cmp_val   (cmp_val),
    .irq_ack   (irq_ack),
    .ext_count (ext_count),
    .ovf_pulse (ovf_pulse),
    .unf_pulse (unf_pulse),
    .step_err  (step_err),
    .ext_ovf   (ext_ovf),
    .match_irq (match_irq)
  );

  // Upstream counter; ovr forces a value the tracker is not told about.
  always @(posedge clk) begin
    if (clr)      cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (ovr) cnt <= ovr_val;
    else if (en)  cnt <= mode ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
  end

  // Reference: ext_count behaves as one wide counter following +/-1 steps.
  logic [W-1:0] m_ext = '0;
  logic m_ovf = 0, m_unf = 0, m_err = 0, m_xovf = 0, m_irq = 0;
  logic m_capture = 1, m_after_reset = 1, m_up_prev = 0;

  always @(posedge clk or negedge rst_n) begin : ref_model
    logic [W-1:0]     old;
    logic [CNT_W-1:0] d;
    if (!rst_n) begin
      m_ext = '0; m_ovf = 0; m_unf = 0; m_err = 0; m_xovf = 0; m_irq = 0;
      m_capture = 1; m_after_reset = 1; m_up_prev = 0;
    end else begin
      old   = m_ext;
      d     = cnt - old[CNT_W-1:0];
      m_ovf = 0;
      m_unf = 0;
`ifdef COUNT_MATCH_IRQ_EN
      m_irq = (old == cmp_val) || (m_irq && !irq_ack);
`endif
      if (m_capture) begin
        m_ext = {{EXT_W{1'b0}}, cnt};
      end else if (d == CNT_W'(1)) begin
        m_ext = old + W'(1);
        if (m_ext[CNT_W-1:0] == '0) m_ovf = 1;
        if (m_ext == '0) m_xovf = 1;
        if (!m_up_prev) m_err = 1;
      end else if (d == '1) begin
        m_ext = old - W'(1);
        if (old[CNT_W-1:0] == '0) m_unf = 1;
        if (old == '0) m_xovf = 1;
        if (m_up_prev) m_err = 1;
      end else if (d != '0) begin
        m_err = 1;
        m_ext[CNT_W-1:0] = cnt;
      end
      m_capture     = !m_after_reset && (ld || clr);
      m_after_reset = 0;
      m_up_prev     = mode;
    end
  end

  function automatic logic [W+4:0] obs();
    return {ext_count, ovf_pulse, unf_pulse, step_err, ext_ovf, match_irq};
  endfunction

  function automatic logic [W+4:0] mdl();
    return {m_ext, m_ovf, m_unf, m_err, m_xovf, m_irq};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_state act=%h exp=0", obs());
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL sync_capture act=%h exp=%h", obs(), mdl());
    end
  endtask

  task automatic test_count_up();
    int novf = 0;
    mode = 1'b1; en = 1'b0; ld = 1'b1; ld_val = 8'h01;
    step();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ovf_pulse) novf++;
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL up_track i=%0d act=%h exp=%h", i, obs(), mdl());
      end
    end
    en = 1'b0;
    repeat (2) begin
      step();
      if (ovf_pulse) novf++;
    end
    n_tests++;
    if (novf != 1) begin
      n_fail++;
      $display("FAIL up_ovf_count act=%0d exp=1", novf);
    end
    n_tests++;
    if ({ext_count, step_err} !== {16'h012D, 1'b0}) begin
      n_fail++;
      $display("FAIL up_final act=%h/%b exp=012d/0", ext_count, step_err);
    end
  endtask

  task automatic test_count_down();
    int nunf = 0;
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 46; i++) begin
      step();
      if (unf_pulse) nunf++;
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL down_track i=%0d act=%h exp=%h", i, obs(), mdl());
      end
    end
    en = 1'b0;
    repeat (2) begin
      step();
      if (unf_pulse) nunf++;
    end
    n_tests++;
    if ({nunf, ext_count, step_err} !== {32'd1, 16'h00FF, 1'b0}) begin
      n_fail++;
      $display("FAIL down_wrap act=unf%0d/%h/%b exp=unf1/00ff/0", nunf, ext_count, step_err);
    end
  endtask

  task automatic test_clear();
    mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 337; i++) begin
      step();
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL clr_prep i=%0d act=%h exp=%h", i, obs(), mdl());
      end
    end
    en = 1'b0;
    repeat (2) step();
    n_tests++;
    if (ext_count !== 16'h0250) begin
      n_fail++;
      $display("FAIL clr_start act=%h exp=0250", ext_count);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    n_tests++;
    if ({ext_count, step_err} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_resync act=%h/%b exp=0000/0", ext_count, step_err);
    end
  endtask

  task automatic test_jump();
    en = 1'b0; mode = 1'b1; ld = 1'b1; ld_val = 8'h10;
    step();
    ld = 1'b0;
    repeat (2) step();
    ovr = 1'b1; ovr_val = 8'h20;
    step();
    ovr = 1'b0;
    step();
    n_tests++;
    if ({ext_count, step_err} !== {16'h0020, 1'b1}) begin
      n_fail++;
      $display("FAIL jump_err act=%h/%b exp=0020/1", ext_count, step_err);
    end
    repeat (3) step();
    n_tests++;
    if (step_err !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_sticky act=%b exp=1", step_err);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    n_tests++;
    if (step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_reset_clear act=%b exp=0", step_err);
    end
    mode = 1'b1; ovr = 1'b1; ovr_val = cnt - 8'h01;
    step();
    ovr = 1'b0;
    step();
    n_tests++;
    if (step_err !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_err act=%b exp=1", step_err);
    end
  endtask

  task automatic test_ext_wrap();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    en = 1'b0; mode = 1'b0; ld = 1'b1; ld_val = 8'h02;
    step();
    ld = 1'b0; en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    step();
    n_tests++;
    if ({ext_count, unf_pulse, ext_ovf} !== {16'hFFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ext_wrap_down act=%h/%b/%b exp=ffff/1/1", ext_count, unf_pulse, ext_ovf);
    end
    mode = 1'b1; en = 1'b1;
    step();
    en = 1'b0;
    step();
    n_tests++;
    if ({ext_count, ovf_pulse, unf_pulse, ext_ovf, step_err} !== {16'h0000, 4'b1010}) begin
      n_fail++;
      $display("FAIL ext_wrap_up act=%h/%b%b%b%b exp=0000/1010",
               ext_count, ovf_pulse, unf_pulse, ext_ovf, step_err);
    end
    step();
    n_tests++;
    if ({ovf_pulse, ext_ovf} !== 2'b01) begin
      n_fail++;
      $display("FAIL ext_ovf_sticky act=%b%b exp=01", ovf_pulse, ext_ovf);
    end
  endtask

  task automatic test_match_irq();
    logic irq_exp;
    logic seen = 1'b0;
`ifdef COUNT_MATCH_IRQ_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cmp_val = 16'h0105; mode = 1'b1; ld = 1'b1; ld_val = 8'h01;
    step();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL irq_track i=%0d act=%h exp=%h", i, obs(), mdl());
      end
      if (ext_count == 16'h0105) begin
        seen = 1'b1;
        n_tests++;
        if (match_irq !== 1'b0) begin
          n_fail++;
          $display("FAIL irq_early act=%b exp=0", match_irq);
        end
        step();
        n_tests++;
        if (match_irq !== irq_exp) begin
          n_fail++;
          $display("FAIL irq_rise act=%b exp=%b", match_irq, irq_exp);
        end
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL irq_timeout act=no_match exp=ext_count_0105");
    end
    en = 1'b0;
    repeat (3) step();
    n_tests++;
    if (match_irq !== irq_exp) begin
      n_fail++;
      $display("FAIL irq_hold act=%b exp=%b", match_irq, irq_exp);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    n_tests++;
    if (match_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_ack act=%b exp=0", match_irq);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; en = 1'b1;
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL async_reset act=%h exp=0", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL post_reset i=%0d act=%h exp=%h", i, obs(), mdl());
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      en      = ($urandom_range(0, 7) != 0);
      ld      = ($urandom_range(0, 63) == 0);
      clr     = ($urandom_range(0, 63) == 0);
      ovr     = ($urandom_range(0, 127) == 0);
      ld_val  = CNT_W'($urandom);
      ovr_val = CNT_W'($urandom);
      irq_ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) cmp_val = m_ext + W'($urandom_range(0, 3));
      step();
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL random i=%0d act=%h exp=%h", i, obs(), mdl());
      end
    end
    ld = 1'b0; clr = 1'b0; ovr = 1'b0; en = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_clear();
    test_jump();
    test_ext_wrap();
    test_match_irq();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
